// File: rtl/mips_pipeline_mem_controller.sv
// ---------------------------------------------------------------------------
// mips_pipeline_mem_controller
//
// Sequencer for the MIPS MEM stage. It sits between the ExMem pipeline
// register and a multi-cycle data memory that uses a req/ack handshake.
// It launches loads and stores, freezes the upstream pipeline until the
// memory answers, and tells the MemWb register each cycle whether to capture
// the current instruction or a bubble. It also provides the captured load
// data on memOut.
//
// Ports
//   clock, reset          single clock; synchronous active-high reset
//   exValid               ExMem holds a valid instruction
//   exMemRead/exMemWrite  load / store (never both)
//   exAddress             byte address (ALU result)
//   exWriteData           store data
//   flush                 squash the instruction in MEM
//   dmemReq               memory request, held until dmemAck
//   dmemWrite             1 = store, 0 = load (registered)
//   dmemAddress           registered request address
//   dmemWriteData         registered store data
//   dmemAck               memory completes the request this cycle
//   dmemReadData          load data, valid with dmemAck
//   stall                 freeze PC, IfId, IdEx and ExMem
//   memWbLoad             MemWb captures the ExMem instruction
//   memWbBubble           MemWb captures the bubble pack
//   memOut                registered load data for MemWb
//   alignError            one-cycle pulse, misaligned memory access
//   busError              one-cycle pulse, access timed out
// ---------------------------------------------------------------------------
module mips_pipeline_mem_controller #(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        exValid,
    input  logic        exMemRead,
    input  logic        exMemWrite,
    input  logic [31:0] exAddress,
    input  logic [31:0] exWriteData,
    input  logic        flush,
    output logic        dmemReq,
    output logic        dmemWrite,
    output logic [31:0] dmemAddress,
    output logic [31:0] dmemWriteData,
    input  logic        dmemAck,
    input  logic [31:0] dmemReadData,
    output logic        stall,
    output logic        memWbLoad,
    output logic        memWbBubble,
    output logic [31:0] memOut,
    output logic        alignError,
    output logic        busError
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Counter value on the last ACCESS cycle allowed before a bus error:
    // the counter starts at 0 on ACCESS cycle 1, so it reads TIMEOUT-1 on
    // ACCESS cycle TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             write_q, write_d;
    logic [31:0]      mem_out_q, mem_out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flush_pending_q, flush_pending_d;

    // Un-gated control decisions; reset forces them to their idle values
    // at the output stage below.
    logic stall_c;
    logic req_c;
    logic load_c;
    logic align_c;
    logic bus_c;

    logic is_mem_op;
    assign is_mem_op = exMemRead | exMemWrite;

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        write_d         = write_q;
        mem_out_d       = mem_out_q;
        cnt_d           = cnt_q;
        flush_pending_d = flush_pending_q;
        stall_c         = 1'b0;
        req_c           = 1'b0;
        load_c          = 1'b0;
        align_c         = 1'b0;
        bus_c           = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (flush || !exValid) begin
                    // squashed or empty slot: bubble
                end else if (!is_mem_op) begin
                    load_c = 1'b1;
                end else if (exAddress[1:0] != 2'b00) begin
                    align_c = 1'b1;
                end else begin
                    stall_c = 1'b1;
                    addr_d  = exAddress;
                    wdata_d = exWriteData;
                    write_d = exMemWrite;
                    cnt_d   = '0;
                    state_d = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                stall_c = 1'b1;
                req_c   = 1'b1;
                // The access is never aborted; a flush only turns the
                // eventual MemWb capture into a bubble.
                if (flush) begin
                    flush_pending_d = 1'b1;
                end
                if (dmemAck) begin
                    if (!write_q) begin
                        mem_out_d = dmemReadData;
                    end
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    bus_c     = 1'b1;
                    mem_out_d = '0;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                load_c          = !(flush_pending_q || flush);
                flush_pending_d = 1'b0;
                state_d         = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            wdata_q         <= '0;
            write_q         <= 1'b0;
            mem_out_q       <= '0;
            cnt_q           <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            write_q         <= write_d;
            mem_out_q       <= mem_out_d;
            cnt_q           <= cnt_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    // Reset overrides the combinational controls in the same cycle so an
    // in-flight request is dropped immediately.
    assign stall         = stall_c & ~reset;
    assign dmemReq       = req_c & ~reset;
    assign memWbLoad     = load_c & ~reset;
    assign memWbBubble   = ~load_c | reset;
    assign alignError    = align_c & ~reset;
    assign busError      = bus_c & ~reset;

    assign dmemAddress   = addr_q;
    assign dmemWriteData = wdata_q;
    assign dmemWrite     = write_q;
    assign memOut        = mem_out_q;

endmodule

// File: tb/tb_mips_pipeline_mem_controller.sv
// ---------------------------------------------------------------------------
// tb_mips_pipeline_mem_controller
//
// Self-checking bench. Each instruction is described at transaction level
// (kind, address, ack latency, per-cycle flush pattern); the expected cycle
// count and per-cycle outputs are derived from the timing rules of the MEM
// stage sequencer. Directed cases come first, then randomized traffic.
// ---------------------------------------------------------------------------
module tb_mips_pipeline_mem_controller;

    localparam int TMO = 4;

    logic        clock;
    logic        reset;
    logic        exValid;
    logic        exMemRead;
    logic        exMemWrite;
    logic [31:0] exAddress;
    logic [31:0] exWriteData;
    logic        flush;
    logic        dmemReq;
    logic        dmemWrite;
    logic [31:0] dmemAddress;
    logic [31:0] dmemWriteData;
    logic        dmemAck;
    logic [31:0] dmemReadData;
    logic        stall;
    logic        memWbLoad;
    logic        memWbBubble;
    logic [31:0] memOut;
    logic        alignError;
    logic        busError;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem_model = 32'h0;

    mips_pipeline_mem_controller #(.TIMEOUT(TMO)) dut (
        .clock        (clock),
        .reset        (reset),
        .exValid      (exValid),
        .exMemRead    (exMemRead),
        .exMemWrite   (exMemWrite),
        .exAddress    (exAddress),
        .exWriteData  (exWriteData),
        .flush        (flush),
        .dmemReq      (dmemReq),
        .dmemWrite    (dmemWrite),
        .dmemAddress  (dmemAddress),
        .dmemWriteData(dmemWriteData),
        .dmemAck      (dmemAck),
        .dmemReadData (dmemReadData),
        .stall        (stall),
        .memWbLoad    (memWbLoad),
        .memWbBubble  (memWbBubble),
        .memOut       (memOut),
        .alignError   (alignError),
        .busError     (busError)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Outputs that must hold in every cycle regardless of state.
    task automatic check_onehot();
        checks++;
        assert ((memWbLoad ^ memWbBubble) === 1'b1) else begin
            errors++;
            $error("FAIL onehot observed=%b%b expected=one-hot", memWbLoad, memWbBubble);
        end
    endtask

    // One instruction. lat = ACCESS cycle (1-based) carrying the ack,
    // 0 = never acked. fm[c] = flush in cycle c of this instruction.
    task automatic run_txn(input logic v, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rdat, input int lat,
                           input logic [15:0] fm);
        bit squash, is_mem, mis, tmo, fl_any, single;
        int n, total;
        logic [31:0] exp_out;
        squash = fm[0] || !v;
        is_mem = rd || wr;
        mis    = (addr[1:0] != 2'b00);
        single = squash || !is_mem || mis;
        tmo    = (lat == 0) || (lat > TMO);
        n      = tmo ? TMO : lat;
        total  = single ? 1 : n + 2;
        fl_any = 1'b0;
        for (int c = 0; c < total; c++) begin
            @(negedge clock);
            exValid      = v;
            exMemRead    = rd;
            exMemWrite   = wr;
            exAddress    = addr;
            exWriteData  = wd;
            flush        = fm[c];
            dmemAck      = (!single && !tmo && c == lat);
            dmemReadData = (c == lat) ? rdat : $urandom;
            #2;
            check_onehot();
            if (single) begin
                check("stall",  stall, 0);
                check("req",    dmemReq, 0);
                check("load",   memWbLoad, (!squash && !is_mem));
                check("align",  alignError, (!squash && is_mem && mis));
                check("bus",    busError, 0);
                check("memout_hold", memOut, mem_model);
            end else if (c == 0) begin
                check("stall_det", stall, 1);
                check("req_det",   dmemReq, 0);
                check("load_det",  memWbLoad, 0);
                check("align_det", alignError, 0);
                check("bus_det",   busError, 0);
            end else if (c <= n) begin
                fl_any = fl_any | fm[c];
                check("stall_acc", stall, 1);
                check("req_acc",   dmemReq, 1);
                check("load_acc",  memWbLoad, 0);
                check("addr_acc",  dmemAddress, addr);
                check("wdata_acc", dmemWriteData, wd);
                check("write_acc", dmemWrite, wr);
                check("bus_acc",   busError, (tmo && c == n));
                check("align_acc", alignError, 0);
            end else begin
                fl_any  = fl_any | fm[c];
                exp_out = tmo ? 32'h0 : (rd ? rdat : mem_model);
                mem_model = exp_out;
                check("stall_done", stall, 0);
                check("req_done",   dmemReq, 0);
                check("load_done",  memWbLoad, !fl_any);
                check("bus_done",   busError, 0);
                check("memout_done", memOut, exp_out);
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        exValid      = 1'b0;
        exMemRead    = 1'b0;
        exMemWrite   = 1'b0;
        exAddress    = 32'h0;
        exWriteData  = 32'h0;
        flush        = 1'b0;
        dmemAck      = 1'b0;
        dmemReadData = 32'h0;

        // Reset held for two cycles.
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            #2;
            check("rst_stall",  stall, 0);
            check("rst_req",    dmemReq, 0);
            check("rst_load",   memWbLoad, 0);
            check("rst_bubble", memWbBubble, 1);
            check("rst_align",  alignError, 0);
            check("rst_bus",    busError, 0);
            if (i == 1) begin
                check("rst_memout", memOut, 0);
                check("rst_addr",   dmemAddress, 0);
            end
        end
        @(negedge clock);
        reset = 1'b0;

        // Load at 0x100, ack on first ACCESS cycle.
        run_txn(1, 1, 0, 32'h100, 32'h0, 32'hDEADBEEF, 1, 16'h0);
        // Store with 3 wait states.
        run_txn(1, 0, 1, 32'h40, 32'h12345678, 32'hA5A5A5A5, 4, 16'h0);
        // Misaligned load.
        run_txn(1, 1, 0, 32'h102, 32'h0, 32'h0, 1, 16'h0);
        // Timeout, then ack exactly on the last allowed cycle.
        run_txn(1, 1, 0, 32'h200, 32'h0, 32'h11111111, 0, 16'h0);
        run_txn(1, 1, 0, 32'h204, 32'h0, 32'h22222222, TMO, 16'h0);
        // Flush during ACCESS.
        run_txn(1, 1, 0, 32'h300, 32'h0, 32'h33333333, 2, 16'h0002);
        // Mixed stream: non-mem (flushed), load, non-mem.
        run_txn(1, 0, 0, 32'h5, 32'h0, 32'h0, 1, 16'h0001);
        run_txn(1, 1, 0, 32'h80, 32'h0, 32'h44444444, 1, 16'h0);
        run_txn(1, 0, 0, 32'h6, 32'h0, 32'h0, 1, 16'h0);

        // Reset asserted in the middle of an access.
        @(negedge clock);
        exValid = 1'b1; exMemRead = 1'b1; exMemWrite = 1'b0;
        exAddress = 32'h400; flush = 1'b0; dmemAck = 1'b0;
        #2;
        check("midrst_det", stall, 1);
        @(negedge clock);
        #2;
        check("midrst_req_before", dmemReq, 1);
        reset = 1'b1;
        #1;
        check("midrst_req_drop", dmemReq, 0);
        check("midrst_bubble",   memWbBubble, 1);
        @(negedge clock);
        reset = 1'b0;
        exValid = 1'b0;
        #2;
        check("midrst_idle_req", dmemReq, 0);
        check("midrst_idle_stall", stall, 0);
        check("midrst_memout", memOut, 0);
        mem_model = 32'h0;

        // Randomized traffic.
        for (int t = 0; t < 150; t++) begin
            logic v, rd, wr;
            logic [31:0] addr;
            logic [15:0] fm;
            int kind;
            v    = ($urandom_range(0, 9) != 0);
            kind = $urandom_range(0, 2);
            rd   = (kind == 1);
            wr   = (kind == 2);
            addr = $urandom;
            if ($urandom_range(0, 6) != 0) addr[1:0] = 2'b00;
            fm = 16'h0;
            for (int b = 0; b < 16; b++) fm[b] = ($urandom_range(0, 9) == 0);
            run_txn(v, rd, wr, addr, $urandom, $urandom, $urandom_range(0, 6), fm);
        end

        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_pipeline_mem_controller.md
# mips_pipeline_mem_controller

Sequencer for the MIPS pipeline MEM stage. It sits between the ExMem pipeline register and a multi-cycle data memory with a req/ack handshake. It launches loads and stores, freezes the upstream pipeline until the memory answers, and tells the MemWb register each cycle whether to capture the instruction or a bubble. It also supplies the captured read data as `memOut`, the word consumed when MemWb is generated.

## Interface
- `TIMEOUT`, default 255: maximum ACCESS cycles before a bus error is declared; legal range 1..65535.
- `clock`  in  1: single clock, all state on rising edge.
- `reset`  in  1: synchronous, active-high.
- `exValid`  in  1: ExMem holds a valid instruction.
- `exMemRead`  in  1: instruction is a load.
- `exMemWrite`  in  1: instruction is a store. Never both read and write.
- `exAddress`  in  32: byte address, ALU result.
- `exWriteData`  in  32: store data.
- `flush`  in  1: squash the instruction in MEM.
- `dmemReq`  out  1: memory request, held until ack.
- `dmemWrite`  out  1: 1 = store, 0 = load.
- `dmemAddress`  out  32: registered request address.
- `dmemWriteData`  out  32: registered store data.
- `dmemAck`  in  1: memory completes the request this cycle.
- `dmemReadData`  in  32: load data, valid with `dmemAck`.
- `stall`  out  1: freeze PC, IfId, IdEx and ExMem.
- `memWbLoad`  out  1: MemWb captures the current ExMem instruction.
- `memWbBubble`  out  1: MemWb captures the default (bubble) pack.
- `memOut`  out  32: registered load data to MemWb.
- `alignError`  out  1: one-cycle pulse, misaligned access.
- `busError`  out  1: one-cycle pulse, timeout.

## Operation
- States: IDLE, ACCESS, DONE. Registered outputs: `dmemAddress`, `dmemWriteData`, `dmemWrite`, `memOut`, a timeout counter of width clog2(TIMEOUT+1), and a `flushPending` bit.
- **Reset.** State goes to IDLE; all registers and the counter go to 0. While `reset` is high, outputs are `stall`=0, `dmemReq`=0, `memWbLoad`=0, `memWbBubble`=1, and both error pulses are 0.
- **One-hot load/bubble.** Outside reset, exactly one of `memWbLoad` and `memWbBubble` is 1 every cycle.
- **IDLE, priority order.**
  1. `flush` or !`exValid`: bubble, no stall.
  2. Non-memory instruction: `memWbLoad`=1, no stall.
  3. Memory op with `exAddress[1:0]`!=0: `alignError`=1, bubble, no stall, no request.
  4. Otherwise (memory op, aligned): `stall`=1, bubble; register address, data and write; clear the counter; go to ACCESS.
- **ACCESS.** `dmemReq`=1, `stall`=1, bubble.
  - `flush` sets `flushPending`. An in-flight access is never aborted.
  - On `dmemAck`: latch `dmemReadData` into `memOut` (loads only; stores leave `memOut` unchanged) and go to DONE.
  - Otherwise the counter increments. When the counter equals TIMEOUT-1 with no ack: pulse `busError`, set `memOut`=0, go to DONE.
- **DONE.** `stall`=0, `dmemReq`=0.
  - `memWbLoad`=1, or `memWbBubble`=1 if `flushPending` or `flush` is set.
  - Clear `flushPending` and go to IDLE.
- Register address and data are held stable for the whole ACCESS state.

## Timing
- Non-memory instruction: passes in 1 cycle, no stall.
- Memory op with ack on the first ACCESS cycle:
  - cycle 0: IDLE detects it, `stall`=1.
  - cycle 1: ACCESS, ack arrives.
  - cycle 2: DONE, `memWbLoad`=1, `stall`=0.
  - Minimum total: 3 cycles, 2 of them stalled.
- Each extra wait cycle adds one stall cycle.
- Timeout: `busError` fires on ACCESS cycle TIMEOUT. An ack on that same cycle wins, and there is no error.
- `dmemReq` rises the cycle after detection and falls the cycle after ack. It is never asserted in IDLE or DONE.
- Back-to-back memory ops: DONE → IDLE detects the next op the following cycle. There is 1 non-stalled cycle between the two.
- Reset asserted mid-ACCESS drops `dmemReq` on the same edge; the memory must tolerate an abandoned request.

## Test plan
- **Reset.** Hold `reset` 2 cycles, then load at 0x100, ack on the first ACCESS cycle with data 0xDEADBEEF.
  - `dmemReq` high for 1 cycle with `dmemAddress`=0x100.
  - `memOut`=0xDEADBEEF in DONE.
  - `stall` high for exactly 2 cycles.
- **Store with wait states.** Store 0x12345678 to 0x40, ack after 3 wait cycles.
  - `dmemWrite`=1 and data held for 4 ACCESS cycles.
  - `stall` high for 5 cycles, then 1 `memWbLoad`.
  - `memOut` unchanged.
- **Misaligned load.** Load at 0x102.
  - `alignError` pulses once, `dmemReq` never rises, bubble, `stall`=0.
- **Timeout.** With TIMEOUT=4, a load that is never acked.
  - `busError` on ACCESS cycle 4, `memOut`=0, DONE loads.
  - Repeat with ack on cycle 4: no `busError`.
- **Flush during ACCESS.** Load, `flush` pulsed on the 1st ACCESS cycle, ack on the 2nd.
  - Request completes.
  - DONE gives `memWbBubble`=1 and `memWbLoad`=0.
- **Mixed stream.** Non-mem, load (ack first cycle), non-mem, with `flush` on the first.
  - Per-cycle `memWbLoad`/`memWbBubble` sequence is B, B, B, L, L.
  - Exactly one of the two is high every cycle.
